// File: rtl/mul_pipe_unit_pkg.sv
// Shared definitions for the two-stage multiply unit: op encodings and S1 payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_pipe_unit_pkg;

    localparam logic [1:0] MUL_OP_W     = 2'b00;
    localparam logic [1:0] MUL_OP_MULH  = 2'b01;
    localparam logic [1:0] MUL_OP_MULHU = 2'b10;

    // Tag field width of the S1 payload; the top-level TAG_W defaults to this.
    localparam int MUL_TAG_W = 5;

    typedef struct packed {
        logic [31:0]          x;
        logic [31:0]          y;
        logic [1:0]           op;
        logic [MUL_TAG_W-1:0] tag;
    } s1_pay_t;

    // High-word ops; everything else (including reserved 11) returns the low word.
    function automatic logic sel_high(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHU);
    endfunction

endpackage

// File: rtl/mul_pipe_unit_mul.sv
// Combinational 32x32 array multiplier, signed or unsigned, full 64-bit product.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
module mul (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        mul_signed,
    output logic [63:0] result
);

    logic [63:0] x_ext;
    logic [63:0] y_ext;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
    always_comb begin
        x_ext  = {{32{mul_signed & x[31]}}, x};
        y_ext  = {{32{mul_signed & y[31]}}, y};
        result = x_ext * y_ext;
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// Two-stage multiply unit (MUL.W / MULH.W / MULH.WU) with tag pass-through and flush.
// Latency: 2 cycles from input transfer to out_valid; one op per cycle when unstalled.
// Backpressure: out_ready low holds S2 and S1; in_ready falls only when both are full.
// Optional MUL_STAT_EN adds stat_ops / stat_stall counters.
module mul_pipe_unit
    import mul_pipe_unit_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_STAT_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_stall
`endif
);

    s1_pay_t          s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    logic [31:0]      s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             s1_load;
    logic [63:0]      product;
    logic [31:0]      res_sel;

    mul u_mul (
        .x          (s1_q.x),
        .y          (s1_q.y),
        .mul_signed (s1_q.op == MUL_OP_MULH),
        .result     (product)
    );

    // Handshake and next-state for both stages; flush overrides every other event.
    always_comb begin
        s2_adv   = !s2_vld_q || out_ready;
        s1_adv   = s1_vld_q && s2_adv;
        s1_load  = !s1_vld_q || s2_adv;
        in_ready = s1_load && !flush;
        res_sel  = sel_high(s1_q.op) ? product[63:32] : product[31:0];

        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        s2_tag_d = s2_tag_q;

        if (flush) begin
            s1_vld_d = 1'b0;
        end else if (s1_load) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_d.x   = in_x;
                s1_d.y   = in_y;
                s1_d.op  = in_op;
                s1_d.tag = in_tag;
            end
        end

        if (flush) begin
            s2_vld_d = 1'b0;
        end else if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_adv) begin
                s2_res_d = res_sel;
                s2_tag_d = s1_q.tag;
            end
        end
    end

    // Pipeline registers; data is cleared too so the outputs read 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
            s2_tag_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            s2_tag_q <= s2_tag_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_result = s2_res_q;
    assign out_tag    = s2_tag_q;

`ifdef MUL_STAT_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Transfer and stall counters; they wrap and deliberately ignore flush.
    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_stall_d = stat_stall_q;
        if (s2_vld_q && out_ready)  stat_ops_d   = stat_ops_q + 32'd1;
        if (s2_vld_q && !out_ready) stat_stall_d = stat_stall_q + 32'd1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: arithmetic, backpressure, flush, reset, stats.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_mul_pipe_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
`ifdef MUL_STAT_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    mul_pipe_unit #(.TAG_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef MUL_STAT_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
    endtask

    // Issue one op with out_ready high and check it two cycles later.
    task automatic run_one(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] tag, input logic [31:0] exp, input string name);
        out_ready = 1'b1;
        drive(op, x, y, tag);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk({name, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_res"}, out_result, exp);
        chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);

        // Basic MUL.W with explicit latency check
        @(negedge clock);
        out_ready = 1'b1;
        drive(2'b00, 32'd7, 32'd6, 5'd3);
        #1 chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("basic_lat1_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        chk("basic_vld", {31'd0, out_valid}, 32'd1);
        chk("basic_res", out_result, 32'h0000_002A);
        chk("basic_tag", {27'd0, out_tag}, 32'd3);

        // Arithmetic corners
        run_one(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, "mulh_m1m1");
        run_one(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, "mulh_minmin");
        run_one(2'b01, 32'h8000_0000, 32'h0000_0001, 5'd6, 32'hFFFF_FFFF, "mulh_min1");
        run_one(2'b10, 32'h8000_0000, 32'h0000_0001, 5'd7, 32'h0000_0000, "mulhu_min1");
        run_one(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, "mulhu_m1m1");
        run_one(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, "mulw_m1m1");
        run_one(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd10, 32'hFFFF_FFFE, "op11_low");
        @(negedge clock);
        chk("drain_vld", {31'd0, out_valid}, 32'd0);

        // Backpressure: four ops, results 10,20,30,40 with tags 10..13
        out_ready = 1'b0;
        drive(2'b00, 32'd10, 32'd1, 5'd10);
        #1 chk("bp_acc0", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        drive(2'b00, 32'd10, 32'd2, 5'd11);
        #1 chk("bp_acc1", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        drive(2'b00, 32'd10, 32'd3, 5'd12);
        #1 chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold0_res", out_result, 32'd10);
        @(negedge clock);
        chk("bp_hold1_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold1_res", out_result, 32'd10);
        chk("bp_hold1_tag", {27'd0, out_tag}, 32'd10);
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        chk("bp_r1_res", out_result, 32'd20);
        chk("bp_r1_tag", {27'd0, out_tag}, 32'd11);
        drive(2'b00, 32'd10, 32'd4, 5'd13);
        @(negedge clock);
        in_valid = 1'b0;
        chk("bp_r2_res", out_result, 32'd30);
        chk("bp_r2_tag", {27'd0, out_tag}, 32'd12);
        @(negedge clock);
        chk("bp_r3_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_r3_res", out_result, 32'd40);
        chk("bp_r3_tag", {27'd0, out_tag}, 32'd13);
        @(negedge clock);
        chk("bp_empty_vld", {31'd0, out_valid}, 32'd0);

        // Flush with both stages full; the op offered alongside flush is dropped
        out_ready = 1'b0;
        drive(2'b00, 32'd2, 32'd2, 5'd20);
        @(negedge clock);
        drive(2'b00, 32'd3, 32'd3, 5'd21);
        @(negedge clock);
        chk("fl_full_vld", {31'd0, out_valid}, 32'd1);
        drive(2'b00, 32'd4, 32'd4, 5'd22);
        flush = 1'b1;
        #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_vld_next", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(2'b00, 32'd5, 32'd5, 5'd7);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("rm_pre_vld", {31'd0, out_valid}, 32'd1);
        chk("rm_pre_res", out_result, 32'd25);
        #2 reset = 1'b1;
        #1;
        chk("rm_async_vld", {31'd0, out_valid}, 32'd0);
        chk("rm_async_res", out_result, 32'd0);
        chk("rm_async_tag", {27'd0, out_tag}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rm_rel_rdy", {31'd0, in_ready}, 32'd1);
        chk("rm_rel_vld", {31'd0, out_valid}, 32'd0);
        run_one(2'b00, 32'd9, 32'd9, 5'd1, 32'd81, "rm_first");
        @(negedge clock);

`ifdef MUL_STAT_EN
        // Statistics: 5 transfers, 3 stall cycles, unaffected by flush
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
        chk("st_rst_ops", stat_ops, 32'd0);
        chk("st_rst_stall", stat_stall, 32'd0);
        out_ready = 1'b0;
        drive(2'b00, 32'd3, 32'd3, 5'd1);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
        run_one(2'b00, 32'd1, 32'd2, 5'd2, 32'd2, "st_op2");
        run_one(2'b00, 32'd1, 32'd3, 5'd3, 32'd3, "st_op3");
        run_one(2'b00, 32'd1, 32'd4, 5'd4, 32'd4, "st_op4");
        run_one(2'b00, 32'd1, 32'd5, 5'd5, 32'd5, "st_op5");
        @(negedge clock);
        chk("st_ops", stat_ops, 32'd5);
        chk("st_stall", stat_stall, 32'd3);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("st_fl_ops", stat_ops, 32'd5);
        chk("st_fl_stall", stat_stall, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
